i2s_rx_sequencer: RTL
=====================

// Module: i2s_rx_sequencer
// PURPOSE
//  I2S master-receive controller for the user project. Generates SCK and WS from
//  wb_clk_i with a programmable divider and captures serial data from the SD pad.
//  Emits left/right sample pairs through a small FIFO with a valid/ready stream.
//  Sits between the I/O pads (SCK/WS out, SD in) and the Wishbone register block.
// PARAMETERS
//  DATA_W      24  captured bits per channel, MSB first; 1..32
//  DIV_W       8   width of the SCK half-period divider input
//  FIFO_DEPTH  4   sample-pair FIFO entries; power of 2, >=2
// PORTS
//  wb_clk_i      in   1       system clock, sole clock domain
//  wb_rst_ni     in   1       asynchronous active-low reset
//  en_i          in   1       run request; level-sensitive
//  div_i         in   DIV_W   SCK half-period = max(div_i,2)+1 clocks; latched on start
//  ovr_clr_i     in   1       clears ovr_o (1-cycle pulse)
//  sd_i          in   1       SD pad input, asynchronous
//  sck_o         out  1       I2S bit clock
//  ws_o          out  1       I2S word select (0 = left, 1 = right)
//  pad_oeb_o     out  2       {ws,sck} output-enable-bar; 2'b11 in IDLE, else 2'b00
//  busy_o        out  1       high in RUN or STOP
//  smp_valid_o   out  1       FIFO head valid
//  smp_ready_i   in   1       consumer accepts head
//  smp_left_o    out  DATA_W  head left sample
//  smp_right_o   out  DATA_W  head right sample
//  ovr_o         out  1       sticky overrun flag
// BEHAVIOUR
//  Reset: sck_o=0, ws_o=0, pad_oeb_o=2'b11, busy_o=0, smp_valid_o=0, ovr_o=0,
//   smp_*_o=0, FIFO empty, FSM=IDLE, counters=0. sd_i passes a 2-flop synchroniser.
//  FSM IDLE->RUN: en_i=1; latch H=max(div_i,2); frame period p=0; sck_o held 0.
//   RUN->STOP: en_i=0 sampled at any point; frame continues to completion.
//   STOP->IDLE: on the falling edge that ends period 63 (sck_o=0, ws_o=0).
//   en_i re-asserted during STOP is ignored until IDLE is reached.
//  SCK: a half-period counter counts 0..H; on reaching H it toggles sck_o and wraps.
//   Each period p: low phase (H+1 clocks), then high phase (H+1 clocks).
//  Rising edge (sck_o 0->1 register update): sample synchronised SD.
//   p in 0..DATA_W-1 -> left shift register; p in 32..32+DATA_W-1 -> right.
//   Bits at other p are ignored.
//  Falling edge (1->0): p <= (p+1) mod 64. ws_o updates in the same clock:
//   ws_o=1 for new p in 31..62, else 0 (WS leads MSB by one SCK period).
//  Push: a {left,right} pair is pushed in the clock after the rising edge of
//   period 32+DATA_W-1.
//   FIFO full and no pop in that cycle -> pair dropped, ovr_o<=1.
//   Full with simultaneous pop -> push accepted, no overrun.
//  ovr_o stays 1 until ovr_clr_i; a set event in the same cycle as clear wins (ovr_o=1).
//  Stream: pop on smp_valid_o & smp_ready_i. smp_valid_o rises one clock after a
//   push into an empty FIFO (no bypass). Head data is stable while valid & !ready.
//  FIFO contents survive en_i toggling; only wb_rst_ni clears them.
//  Async reset mid-frame: outputs return to reset values immediately; the partial
//   frame is discarded.
// TESTING
//  T1 div_i=2, en_i=1, SD drives L=0xA5A5A5, R=0x5A5A5A MSB-first, ready=1 ->
//     sck_o period 6 clks; one pair L=0xA5A5A5/R=0x5A5A5A; valid 1 clk after push.
//  T2 WS timing, div_i=5 -> ws_o rises at the start of p=31 and falls at the start
//     of p=63; ws_o=0 at the first left MSB rising edge.
//  T3 ready=0, 5 frames of distinct data -> 4 pairs held, 5th dropped, ovr_o=1;
//     drain yields frames 1-4 in order; ovr_clr_i -> ovr_o=0.
//  T4 en_i dropped at p=10 -> frame completes, pair pushed, busy_o falls after
//     p=63 falling edge, sck_o=0, pad_oeb_o=2'b11.
//  T5 wb_rst_ni pulsed low at p=40 -> all outputs at reset values immediately;
//     re-enable gives a clean frame from p=0.
//  T6 div_i=0 -> clamped; sck_o period 6 clks, same as div_i=2.

Source files
------------

// File: rtl/i2s_rx_sequencer.sv
// I2S master-receive controller: generates SCK/WS, captures SD MSB-first per channel,
// and queues {left,right} sample pairs in a small FIFO behind a valid/ready stream.
module i2s_rx_sequencer #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic              ovr_clr_i,
  input  logic              sd_i,
  output logic              sck_o,
  output logic              ws_o,
  output logic [1:0]        pad_oeb_o,
  output logic              busy_o,
  output logic              smp_valid_o,
  input  logic              smp_ready_i,
  output logic [DATA_W-1:0] smp_left_o,
  output logic [DATA_W-1:0] smp_right_o,
  output logic              ovr_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic [5:0] P_LAST_R = 6'(32 + DATA_W - 1);

  logic [1:0]       state_q;
  logic [DIV_W-1:0] h_q, cnt_q, div_clamped;
  logic             sck_q, ws_q;
  logic [5:0]       p_q, p_next;
  logic             sd_meta_q, sd_sync_q;
  logic [DATA_W-1:0] left_sh_q, right_sh_q;
  logic             push_q;
  logic             active, half_done, rise, fall;

  assign div_clamped = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;
  assign active      = (state_q != ST_IDLE);
  assign half_done   = (cnt_q == h_q);
  assign rise        = active & half_done & ~sck_q;
  assign fall        = active & half_done & sck_q;
  assign p_next      = p_q + 6'd1;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sd_meta_q <= 1'b0;
      sd_sync_q <= 1'b0;
    end else begin
      sd_meta_q <= sd_i;
      sd_sync_q <= sd_meta_q;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      cnt_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      p_q     <= '0;
    end else if (state_q == ST_IDLE) begin
      if (en_i) begin
        state_q <= ST_RUN;
        h_q     <= div_clamped;
        cnt_q   <= '0;
        sck_q   <= 1'b0;
        ws_q    <= 1'b0;
        p_q     <= '0;
      end
    end else begin
      if (state_q == ST_RUN && !en_i) state_q <= ST_STOP;
      if (half_done) begin
        cnt_q <= '0;
        sck_q <= ~sck_q;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
      // WS leads the left MSB by one SCK period, so it tracks the new period index.
      if (fall) begin
        p_q  <= p_next;
        ws_q <= (p_next >= 6'd31) && (p_next <= 6'd62);
        if (state_q == ST_STOP && p_q == 6'd63) state_q <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      left_sh_q  <= '0;
      right_sh_q <= '0;
      push_q     <= 1'b0;
    end else begin
      push_q <= rise && (p_q == P_LAST_R);
      if (rise) begin
        if ({26'd0, p_q} < DATA_W) begin
          left_sh_q <= (left_sh_q << 1) | DATA_W'(sd_sync_q);
        end
        if (p_q >= 6'd32 && {26'd0, p_q} < 32 + DATA_W) begin
          right_sh_q <= (right_sh_q << 1) | DATA_W'(sd_sync_q);
        end
      end
    end
  end

  logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              empty, full, pop, wr_en;
  logic [AW-1:0]     wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign pop    = ~empty & smp_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en  = push_q & (~full | pop);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_o    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_l[wr_idx] <= left_sh_q;
        mem_r[wr_idx] <= right_sh_q;
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_q && full && !pop) ovr_o <= 1'b1;
      else if (ovr_clr_i)         ovr_o <= 1'b0;
    end
  end

  assign sck_o       = sck_q;
  assign ws_o        = ws_q;
  assign busy_o      = active;
  assign pad_oeb_o   = active ? 2'b00 : 2'b11;
  assign smp_valid_o = ~empty;
  assign smp_left_o  = empty ? '0 : mem_l[rd_idx];
  assign smp_right_o = empty ? '0 : mem_r[rd_idx];

endmodule
